// File: rtl/boot_led_seq.sv
// Power-up LED sequencer: all-on, all-off, optional walking-one chase, then
// hands the LEDs to functional control with a fault-blink override.
module boot_led_seq #(
  parameter int NUM_LED   = 4,
  parameter int ON_CYC    = 40000000,
  parameter int OFF_CYC   = 40000000,
  parameter int CHASE_EN  = 1,
  parameter int CHASE_CYC = 10000000,
  parameter int CHASE_DIR = 0,
  parameter int BLINK_CYC = 20000000
) (
  input  logic               i_clk,
  input  logic               i_res,
  input  logic [NUM_LED-1:0] i_led,
  input  logic               i_restart,
  input  logic               i_fault,
  output logic [NUM_LED-1:0] o_led,
  output logic               o_busy,
  output logic               o_done
);

  localparam int MAX_BOOT = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int MAX_PH   = (MAX_BOOT > CHASE_CYC) ? MAX_BOOT : CHASE_CYC;
  localparam int MAX_CYC  = (MAX_PH > BLINK_CYC) ? MAX_PH : BLINK_CYC;
  localparam int CNT_W    = $clog2(MAX_CYC) + 1;
  localparam int IDX_W    = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0] CHASE_LAST = CNT_W'(CHASE_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_LED - 1);

  typedef enum logic [1:0] {S_ON, S_OFF, S_CHASE, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   lit_idx;
  logic [NUM_LED-1:0] chase_led;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state_q <= S_ON;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; restart outranks every phase transition.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    if (i_restart) begin
      state_d = S_ON;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_ON: begin
          if (cnt_q == ON_LAST) begin
            state_d = S_OFF;
            cnt_d   = '0;
          end
        end
        S_OFF: begin
          if (cnt_q == OFF_LAST) begin
            state_d = (CHASE_EN != 0) ? S_CHASE : S_RUN;
            cnt_d   = '0;
          end
        end
        S_CHASE: begin
          if (cnt_q == CHASE_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  assign lit_idx   = (CHASE_DIR != 0) ? (IDX_LAST - idx_q) : idx_q;
  assign chase_led = NUM_LED'(1) << lit_idx;

  // Output decode; o_done fires on the first RUN cycle while busy is still high.
  always_comb begin
    led_d       = '1;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    blink_cnt_d = '0;
    blink_ph_d  = 1'b1;
    if (!i_restart) begin
      case (state_q)
        S_ON:    led_d = '1;
        S_OFF:   led_d = '0;
        S_CHASE: led_d = chase_led;
        default: begin
          busy_d = 1'b0;
          done_d = busy_q;
          if (i_fault) begin
            led_d = blink_ph_q ? '1 : '0;
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              blink_ph_d  = ~blink_ph_q;
            end else begin
              blink_cnt_d = blink_cnt_q + CNT_W'(1);
              blink_ph_d  = blink_ph_q;
            end
          end else begin
            led_d = i_led;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      led_q       <= '1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_boot_led_seq.sv
// Bench for boot_led_seq: three variants (chase up, chase down, no chase)
// checked every cycle against an elapsed-time model plus literal sequences.
module tb_boot_led_seq;

  localparam int ON_C    = 4;
  localparam int OFF_C   = 3;
  localparam int CHASE_C = 2;
  localparam int BLINK_C = 5;
  localparam int NL      = 4;

  logic          clk = 1'b0;
  logic          i_res = 1'b1;
  logic [NL-1:0] i_led = 4'b1010;
  logic          i_restart = 1'b0;
  logic          i_fault = 1'b0;

  logic [NL-1:0] led_a, led_b, led_c;
  logic          busy_a, busy_b, busy_c;
  logic          done_a, done_b, done_c;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  boot_led_seq #(.NUM_LED(NL), .ON_CYC(ON_C), .OFF_CYC(OFF_C), .CHASE_EN(1),
                 .CHASE_CYC(CHASE_C), .CHASE_DIR(0), .BLINK_CYC(BLINK_C)) dut_a (
    .i_clk(clk), .i_res(i_res), .i_led(i_led), .i_restart(i_restart),
    .i_fault(i_fault), .o_led(led_a), .o_busy(busy_a), .o_done(done_a));

  boot_led_seq #(.NUM_LED(NL), .ON_CYC(ON_C), .OFF_CYC(OFF_C), .CHASE_EN(1),
                 .CHASE_CYC(CHASE_C), .CHASE_DIR(1), .BLINK_CYC(BLINK_C)) dut_b (
    .i_clk(clk), .i_res(i_res), .i_led(i_led), .i_restart(i_restart),
    .i_fault(i_fault), .o_led(led_b), .o_busy(busy_b), .o_done(done_b));

  boot_led_seq #(.NUM_LED(NL), .ON_CYC(ON_C), .OFF_CYC(OFF_C), .CHASE_EN(0),
                 .CHASE_CYC(CHASE_C), .CHASE_DIR(0), .BLINK_CYC(BLINK_C)) dut_c (
    .i_clk(clk), .i_res(i_res), .i_led(i_led), .i_restart(i_restart),
    .i_fault(i_fault), .o_led(led_c), .o_busy(busy_c), .o_done(done_c));

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Model: the boot pattern is a pure function of cycles elapsed since reset/restart.
  int          m_pos   [3] = '{0, 0, 0};
  int          m_blink [3] = '{0, 0, 0};
  logic [3:0]  m_led   [3] = '{4'hF, 4'hF, 4'hF};
  logic        m_busy  [3] = '{1'b1, 1'b1, 1'b1};
  logic        m_done  [3] = '{1'b0, 1'b0, 1'b0};

  function automatic int boot_len(input int c);
    return (c == 2) ? ON_C + OFF_C : ON_C + OFF_C + NL * CHASE_C;
  endfunction

  function automatic logic [3:0] boot_pattern(input int c, input int pos);
    int k;
    if (pos < ON_C) return 4'hF;
    if (pos < ON_C + OFF_C) return 4'h0;
    k = (pos - ON_C - OFF_C) / CHASE_C;
    if (c == 1) k = NL - 1 - k;
    return 4'(1 << k);
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (i_res || i_restart) begin
        m_led[c] = 4'hF; m_busy[c] = 1'b1; m_done[c] = 1'b0;
        m_pos[c] = 0;    m_blink[c] = 0;
      end else if (m_pos[c] < boot_len(c)) begin
        m_led[c] = boot_pattern(c, m_pos[c]);
        m_busy[c] = 1'b1; m_done[c] = 1'b0;
        m_pos[c]++;       m_blink[c] = 0;
      end else begin
        m_busy[c] = 1'b0;
        m_done[c] = (m_pos[c] == boot_len(c));
        m_pos[c]  = boot_len(c) + 1;
        if (i_fault) begin
          m_led[c] = (((m_blink[c] / BLINK_C) % 2) == 0) ? 4'hF : 4'h0;
          m_blink[c]++;
        end else begin
          m_led[c]   = i_led;
          m_blink[c] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("a_led",  led_a,  m_led[0]);
      check("a_busy", busy_a, m_busy[0]);
      check("a_done", done_a, m_done[0]);
      check("b_led",  led_b,  m_led[1]);
      check("b_busy", busy_b, m_busy[1]);
      check("b_done", done_b, m_done[1]);
      check("c_led",  led_c,  m_led[2]);
      check("c_busy", busy_c, m_busy[2]);
      check("c_done", done_c, m_done[2]);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] lit_a [16] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1,
                             4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'hA};
  logic [3:0] lit_b [16] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h8,
                             4'h8, 4'h4, 4'h4, 4'h2, 4'h2, 4'h1, 4'h1, 4'hA};
  logic [3:0] lit_c [16] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hA,
                             4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
  logic [3:0] toggles [8] = '{4'h5, 4'hA, 4'h3, 4'hC, 4'h0, 4'hF, 4'h6, 4'h9};
  logic [19:0] blink_pat = 20'b11111000001111100000;
  int done_cnt;

  initial begin
    // Reset state.
    cyc(2);
    check_en = 1'b1;
    cyc();
    check("rst_led", led_a, 4'hF);
    check("rst_busy", busy_a, 1'b1);
    check("rst_done", done_a, 1'b0);

    // Full boot from reset release, literal sequences for all three variants.
    i_res = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      check("lit_a_led", led_a, lit_a[i]);
      check("lit_b_led", led_b, lit_b[i]);
      check("lit_c_led", led_c, lit_c[i]);
      check("lit_a_done", done_a, (i == 15));
      check("lit_a_busy", busy_a, (i < 15));
      check("lit_c_done", done_c, (i == 7));
    end

    // Passthrough with one cycle of latency.
    for (int i = 0; i < 8; i++) begin
      i_led = toggles[i];
      cyc();
      check("pass_led", led_a, toggles[i]);
      check("pass_done", done_a, 1'b0);
    end

    // Fault blink, release, re-fault.
    i_fault = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("blink_led", led_a, blink_pat[19-i] ? 4'hF : 4'h0);
    end
    i_fault = 1'b0;
    i_led   = 4'h6;
    cyc();
    check("unfault_led", led_a, 4'h6);
    cyc(2);
    i_fault = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("reblink_led", led_a, (i < 5) ? 4'hF : 4'h0);
    end

    // Restart with fault held: mid-chase abort, then abort on the final chase terminal cycle.
    i_restart = 1'b1;
    cyc();
    check("restart_led", led_a, 4'hF);
    check("restart_busy", busy_a, 1'b1);
    i_restart = 1'b0;
    cyc(9);
    i_restart = 1'b1;
    cyc();
    check("mid_chase_restart_led", led_a, 4'hF);
    i_restart = 1'b0;
    done_cnt  = 0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      if (done_a) done_cnt++;
    end
    check("chase_last_led", led_a, 4'h8);
    i_restart = 1'b1;
    cyc();
    if (done_a) done_cnt++;
    check("abort_no_done", done_cnt, 0);
    check("abort_led", led_a, 4'hF);
    i_restart = 1'b0;
    cyc(15);
    check("fault_boot_chase_end", led_a, 4'h8);
    cyc();
    check("fault_boot_blink_led", led_a, 4'hF);
    check("fault_boot_done", done_a, 1'b1);
    check("fault_boot_busy", busy_a, 1'b0);
    i_fault = 1'b0;

    // Reset in the middle of OFF.
    i_restart = 1'b1;
    cyc();
    i_restart = 1'b0;
    cyc(6);
    check("pre_rst_off_led", led_a, 4'h0);
    i_res = 1'b1;
    cyc();
    check("mid_off_rst_led", led_a, 4'hF);
    check("mid_off_rst_busy", busy_a, 1'b1);
    i_res = 1'b0;
    cyc(20);
    check("final_pass_led", led_a, i_led);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
